// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: FSM encoding and port indices shared by the memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshake plus memory macro signals around the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [1:0]              req;
    logic [1:0]              lock;
    logic [1:0]              we;
    logic [2*ADDR_WIDTH-1:0] addr;
    logic [2*DATA_WIDTH-1:0] wdata;
    logic [1:0]              gnt;
    logic [1:0]              rvalid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_write;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    modport slave (
        input  req, lock, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_addr, mem_wdata, mem_write
    );
    modport master (
        output req, lock, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_addr, mem_wdata, mem_write
    );
endinterface

// File: rtl/mem_port_arbiter_cnt.sv
// mem_port_arbiter_cnt: generic register with synchronous load and increment.
module mem_port_arbiter_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) q <= '0;
        else if (load) q <= load_val;
        else if (inc) q <= q + WIDTH'(1);
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one synchronous memory between two ports,
// with an optional bounded bus lock for multi-beat sequences.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LOCK_MAX   = 16
) (
    input logic               clk,
    input logic               async_reset,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    arb_state_e    state, state_nx;
    logic          rr_last, rd_pend, rd_port;
    logic [1:0]    gnt;
    logic [CW-1:0] lock_cnt, cnt_val;
    logic          cnt_load, cnt_inc;
    logic          locked, own, at_max, g;

    mem_port_arbiter_cnt #(.WIDTH(CW)) u_lock_cnt (
        .clk         (clk),
        .async_reset (async_reset),
        .load        (cnt_load),
        .inc         (cnt_inc),
        .load_val    (cnt_val),
        .q           (lock_cnt)
    );

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state   <= ST_IDLE;
            rr_last <= 1'b1;
            rd_pend <= 1'b0;
            rd_port <= 1'b0;
        end else begin
            state   <= state_nx;
            if (gnt != 2'b00) rr_last <= g;
            rd_pend <= |(gnt & ~bus.we);
            rd_port <= g;
        end
    end

    // Falling out of a lock drops straight into the idle rules in the same cycle.
    always_comb begin
        locked = state != ST_IDLE;
        own    = state == ST_LOCK1;
        at_max = lock_cnt == CW'(LOCK_MAX);
        gnt    = 2'b00;
        if (async_reset) gnt = 2'b00;
        else if (locked && at_max && bus.req[!own]) gnt[!own] = 1'b1;
        else if (locked && bus.req[own]) gnt[own] = 1'b1;
        else gnt = (bus.req == 2'b11) ? (rr_last ? 2'b01 : 2'b10) : bus.req;
        g        = gnt[PORT_DMA];
        state_nx = ST_IDLE;
        cnt_load = 1'b1;
        cnt_val  = '0;
        cnt_inc  = 1'b0;
        if (gnt != 2'b00 && bus.lock[g]) begin
            if (locked && g == own) begin
                state_nx = state;
                cnt_load = 1'b0;
                cnt_inc  = !at_max;
            end else begin
                state_nx = g ? ST_LOCK1 : ST_LOCK0;
                cnt_val  = CW'(1);
            end
        end
    end

    always_comb begin
        bus.gnt       = gnt;
        bus.mem_addr  = gnt[PORT_CPU] ? bus.addr[0 +: ADDR_WIDTH]
                      : gnt[PORT_DMA] ? bus.addr[ADDR_WIDTH +: ADDR_WIDTH] : '0;
        bus.mem_wdata = gnt[PORT_CPU] ? bus.wdata[0 +: DATA_WIDTH]
                      : gnt[PORT_DMA] ? bus.wdata[DATA_WIDTH +: DATA_WIDTH] : '0;
        bus.mem_write = |(gnt & bus.we);
        bus.rvalid    = rd_pend ? (rd_port ? 2'b10 : 2'b01) : 2'b00;
        bus.rdata     = rd_pend ? bus.mem_rdata : '0;
    end
endmodule
